// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Build option: FIFO_ARB_STALL_CNT_EN adds the stall_cnt output to the top.
package fifo_arb_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefNReq     = 4;
  localparam int unsigned DefMaxBurst = 8;
  localparam int unsigned StallCntW   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] v);
    return (v == {StallCntW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin owner search: first pending requester after last_owner_i, wrapping at N_REQ-1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_owner_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] owner_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  int unsigned idx;
  logic        hit;

  always_comb begin
    valid_o = 1'b0;
    owner_o = '0;
    idx     = 0;
    hit     = 1'b0;
    // Offsets 1..N_REQ visit every requester once, ending on last_owner itself.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner_i) + k) % N_REQ;
      hit = 1'b0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (j == idx) begin
          hit = req_i[j];
        end
      end
      if (!valid_o && hit) begin
        valid_o = 1'b1;
        owner_o = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter feeding N_REQ requesters into one FIFO write port.
// Build option: FIFO_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned N_REQ     = DefNReq,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  input  logic                     Full,
  output logic                     EN_w,
  output logic [WIDTH-1:0]         data_w
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [StallCntW-1:0]     stall_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);
  localparam logic [CntW-1:0] CntFinal = CntW'(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_owner;
  logic              owner_req;
  logic              owner_last;
  logic [WIDTH-1:0]  owner_data;
  logic              in_burst;
  logic              accept;

  function automatic logic [N_REQ-1:0] onehot(input logic [IdxW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        owner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset forces every output low in the same cycle, even mid-burst.
  assign in_burst = (state_q == BURST) && !RST;
  assign accept   = in_burst && owner_req && !Full;

  always_comb begin
    EN_w   = accept;
    ack    = accept ? onehot(owner_q) : '0;
    grant  = RST ? '0 : grant_q;
    busy   = in_burst;
    data_w = in_burst ? owner_data : '0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    word_cnt_d   = word_cnt_q;
    grant_d      = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BURST;
          owner_d    = pick_owner;
          word_cnt_d = '0;
          grant_d    = onehot(pick_owner);
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
        end else if (!Full) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (owner_last || (word_cnt_q == CntFinal)) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            grant_d      = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LastIdx;
      word_cnt_q   <= '0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      word_cnt_q   <= word_cnt_d;
      grant_q      <= grant_d;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == BURST) && owner_req && Full) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random traffic vs a model.
module tb_fifo_write_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned MB = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic           Full;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           EN_w;
  logic [W-1:0]   data_w;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, expressed as plain integers.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_cnt   = 0;
  int m_stall = 0;

  int ack_log[$];

  always #5 CLK = ~CLK;

  fifo_write_arbiter #(
    .WIDTH     (W),
    .N_REQ     (N),
    .MAX_BURST (MB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .busy      (busy),
    .Full      (Full),
    .EN_w      (EN_w),
    .data_w    (data_w)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check combinational/registered outputs mid-cycle, advance model.
  task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N-1:0] rl,
                       input logic f);
    logic [N-1:0] e_ack, e_grant;
    logic         e_busy, e_en;
    logic [W-1:0] e_data;
    bit           found;
    RST      = rst;
    req      = r;
    req_last = rl;
    Full     = f;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
    e_ack   = '0;
    e_grant = '0;
    e_busy  = 1'b0;
    e_en    = 1'b0;
    e_data  = '0;
    if (!rst && m_busy) begin
      e_grant = N'(1) << m_owner;
      e_busy  = 1'b1;
      e_data  = req_data[m_owner*W +: W];
      if (r[m_owner] && !f) begin
        e_en  = 1'b1;
        e_ack = e_grant;
      end
    end
    @(negedge CLK);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("EN_w", 32'(EN_w), 32'(e_en));
    chk("data_w", data_w, e_data);
`ifdef FIFO_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (ack !== '0) ack_log.push_back(idx_of(ack));
    @(posedge CLK);
    #1;
    if (rst) begin
      m_busy  = 1'b0;
      m_last  = N - 1;
      m_cnt   = 0;
      m_stall = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && r[(m_last + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_last + k) % N;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (f) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_cnt++;
      if (rl[m_owner] || m_cnt == MB) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  int first_ack;
  int exp3[5] = '{0, 1, 2, 3, 0};
  int exp6[3] = '{0, 1, 0};

  initial begin
    RST      = 1'b1;
    req      = '0;
    req_last = '0;
    req_data = '0;
    Full     = 1'b0;
    @(posedge CLK);
    #1;

    // Reset holds outputs low even with requests pending.
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0);

    // Single requester, three-word packet.
    ack_log.delete();
    first_ack = -1;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, (k <= 4) ? 4'b0001 : 4'b0000, (k == 4) ? 4'b0001 : 4'b0000, 1'b0);
      if (first_ack < 0 && ack_log.size() > 0) first_ack = k;
    end
    chk("s2_first_ack_cycle", first_ack, 2);
    chk("s2_ack_count", ack_log.size(), 3);

    // All requesting, one-word packets: rotation with one idle cycle between bursts.
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
    ack_log.delete();
    repeat (10) cycle(1'b0, 4'b1111, 4'b1111, 1'b0);
    chk("s3_ack_count", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) chk("s3_owner", ack_log[i], exp3[i]);

    // Burst cap: requester 2 gets MB words, then requester 3.
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
    ack_log.delete();
    repeat (12) cycle(1'b0, 4'b1100, 4'b0000, 1'b0);
    chk("s4_ack_count", ack_log.size(), 10);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) chk("s4_owner_cap", ack_log[i], 2);
    if (ack_log.size() > 8) chk("s4_next_owner", ack_log[8], 3);

    // Full stall for five cycles mid-burst.
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
    ack_log.delete();
    repeat (3) cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    repeat (5) cycle(1'b0, 4'b0001, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("s5_ack_count", ack_log.size(), 4);
`ifdef FIFO_ARB_STALL_CNT_EN
    chk("s5_stall_cnt", 32'(stall_cnt), 5);
`endif

    // Abandon, then reset mid-burst restores requester 0 priority.
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
    ack_log.delete();
    cycle(1'b0, 4'b0011, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0011, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1111, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1111, 4'b1111, 1'b0);
    chk("s6_ack_count", ack_log.size(), 3);
    for (int i = 0; i < 3 && i < ack_log.size(); i++) chk("s6_owner", ack_log[i], exp6[i]);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 99) == 0),
            N'($urandom) | N'($urandom),
            ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b0000,
            ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
